// File: rtl/imm_decode_pipe.sv
// Single-stage registered immediate decoder: extracts and extends the immediate from a raw
// instruction word, classifies its format, precomputes pc+imm and counts illegal encodings.
module imm_decode_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [XLEN-1:0]  pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [2:0]       fmt,
    output logic [XLEN-1:0]  target,
    output logic [XLEN-1:0]  pc_out,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt,
    input  logic             cnt_clr
);

    localparam logic [2:0] FMT_R     = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHIFT = 3'd6;
    localparam logic [2:0] FMT_ILL   = 3'd7;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP32   = 7'b0111011;

    localparam bit RV64 = (XLEN == 64);

    // Widen an already 32-bit sign-extended value to XLEN, replicating bit 31.
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic signed [31:0] s;
        s = v;
        return XLEN'(s);
    endfunction

    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            is_shift;
    logic            accept;

    assign is_shift = (instr[14:12] == 3'b001) || (instr[14:12] == 3'b101);

    always_comb begin
        dec_imm = '0;
        dec_fmt = FMT_ILL;
        case (instr[6:0])
            OP_LOAD, OP_JALR: begin
                dec_fmt = FMT_I;
                dec_imm = sext32({{20{instr[31]}}, instr[31:20]});
            end
            OP_IMM: begin
                if (!is_shift) begin
                    dec_fmt = FMT_I;
                    dec_imm = sext32({{20{instr[31]}}, instr[31:20]});
                end else if (RV64) begin
                    dec_fmt = FMT_SHIFT;
                    dec_imm = XLEN'(instr[25:20]);
                end else if (!instr[25]) begin
                    dec_fmt = FMT_SHIFT;
                    dec_imm = XLEN'(instr[24:20]);
                end
            end
            OP_IMM32: begin
                // Word-sized shifts only take a 5-bit shamt even on RV64.
                if (RV64 && !is_shift) begin
                    dec_fmt = FMT_I;
                    dec_imm = sext32({{20{instr[31]}}, instr[31:20]});
                end else if (RV64 && !instr[25]) begin
                    dec_fmt = FMT_SHIFT;
                    dec_imm = XLEN'(instr[24:20]);
                end
            end
            OP_STORE: begin
                dec_fmt = FMT_S;
                dec_imm = sext32({{20{instr[31]}}, instr[31:25], instr[11:7]});
            end
            OP_BRANCH: begin
                dec_fmt = FMT_B;
                dec_imm = sext32({{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                                  instr[11:8], 1'b0});
            end
            OP_LUI, OP_AUIPC: begin
                dec_fmt = FMT_U;
                dec_imm = sext32({instr[31:12], 12'b0});
            end
            OP_JAL: begin
                dec_fmt = FMT_J;
                dec_imm = sext32({{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                                  instr[30:21], 1'b0});
            end
            OP_OP: dec_fmt = FMT_R;
            OP_OP32: begin
                if (RV64) dec_fmt = FMT_R;
            end
            default: ;
        endcase
    end

    // Handshake: a transfer happens on any rising edge where valid && ready are both high.
    // The stage accepts whenever its output slot is empty or being drained this cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign illegal  = (fmt == FMT_ILL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            imm       <= '0;
            fmt       <= FMT_R;
            target    <= '0;
            pc_out    <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            imm       <= dec_imm;
            fmt       <= dec_fmt;
            target    <= pc + dec_imm;
            pc_out    <= pc;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_cnt <= '0;
        end else if (cnt_clr) begin
            illegal_cnt <= '0;
        end else if (accept && (dec_fmt == FMT_ILL) && (illegal_cnt != '1)) begin
            illegal_cnt <= illegal_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_imm_decode_pipe.sv
// Bench for imm_decode_pipe: an RV32 instance and an RV64 instance with a 2-bit counter
// share one stimulus stream; a monitor compares both against a reference decoder.
module tb_imm_decode_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        cnt_clr = 1'b0;
    logic [31:0] instr = '0;
    logic [63:0] pc64 = '0;

    logic        in_ready32, out_valid32, illegal32;
    logic [31:0] imm32, target32, pc_out32;
    logic [2:0]  fmt32;
    logic [15:0] cnt32;

    logic        in_ready64, out_valid64, illegal64;
    logic [63:0] imm64, target64, pc_out64;
    logic [2:0]  fmt64;
    logic [1:0]  cnt64;

    int n_checks = 0;
    int n_fail   = 0;

    logic [98:0]  exp32_q[$];
    logic [194:0] exp64_q[$];
    int          cnt32_m = 0;
    int          cnt64_m = 0;
    int          stall_left = 0;
    bit          rand_ready = 0;

    imm_decode_pipe #(.XLEN(32), .CNT_W(16)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
        .instr(instr), .pc(pc64[31:0]), .out_valid(out_valid32), .out_ready(out_ready),
        .imm(imm32), .fmt(fmt32), .target(target32), .pc_out(pc_out32),
        .illegal(illegal32), .illegal_cnt(cnt32), .cnt_clr(cnt_clr)
    );

    imm_decode_pipe #(.XLEN(64), .CNT_W(2)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
        .instr(instr), .pc(pc64), .out_valid(out_valid64), .out_ready(out_ready),
        .imm(imm64), .fmt(fmt64), .target(target64), .pc_out(pc_out64),
        .illegal(illegal64), .illegal_cnt(cnt64), .cnt_clr(cnt_clr)
    );

    // ---------------- clock / reset / watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- reference model
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void ref_decode(input int xlen, input logic [31:0] ins,
                                       output logic [63:0] ri, output logic [2:0] rf);
        longint v;
        logic [6:0] op;
        bit sh;
        v  = 0;
        rf = 3'd7;
        op = ins[6:0];
        sh = (ins[14:12] == 3'd1) || (ins[14:12] == 3'd5);
        if (op == 7'h03 || op == 7'h67 || (op == 7'h13 && !sh) ||
            (op == 7'h1B && !sh && xlen == 64)) begin
            rf = 3'd1; v = longint'($signed(ins[31:20]));
        end else if (op == 7'h13 && sh) begin
            if (xlen == 64) begin
                rf = 3'd6; v = longint'(ins[25:20]);
            end else if (!ins[25]) begin
                rf = 3'd6; v = longint'(ins[24:20]);
            end
        end else if (op == 7'h1B && sh && xlen == 64 && !ins[25]) begin
            rf = 3'd6; v = longint'(ins[24:20]);
        end else if (op == 7'h23) begin
            rf = 3'd2; v = longint'($signed({ins[31:25], ins[11:7]}));
        end else if (op == 7'h63) begin
            rf = 3'd3; v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        end else if (op == 7'h37 || op == 7'h17) begin
            rf = 3'd4; v = longint'($signed({ins[31:12], 12'h000}));
        end else if (op == 7'h6F) begin
            rf = 3'd5; v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
        end else if (op == 7'h33 || (op == 7'h3B && xlen == 64)) begin
            rf = 3'd0;
        end
        ri = v;
        if (xlen == 32) ri[63:32] = 32'h0;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops[12];
        logic [31:0] r;
        ops = '{7'h03, 7'h67, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B, 7'h7F};
        r = $urandom;
        if ($urandom_range(0, 9) != 0) r[6:0] = ops[$urandom_range(0, 11)];
        if ($urandom_range(0, 3) == 0) r[14:12] = ($urandom_range(0, 1) == 0) ? 3'd1 : 3'd5;
        return r;
    endfunction

    // ---------------- driver tasks
    // Inputs change at the falling edge; acceptance is decided from the model's view of
    // the output slot after the monitor has retired anything leaving this cycle.
    task automatic step(input logic v, input logic [31:0] ins, input logic [63:0] p,
                        input logic ordy, input logic clr, output logic acc);
        logic [63:0] ri32, ri64, t;
        logic [2:0]  rf32, rf64;
        @(negedge clk);
        in_valid = v; instr = ins; pc64 = p; out_ready = ordy; cnt_clr = clr;
        #2;
        acc = v && (exp32_q.size() == 0);
        ref_decode(32, ins, ri32, rf32);
        ref_decode(64, ins, ri64, rf64);
        @(posedge clk);
        if (acc) begin
            t = p + ri32;
            exp32_q.push_back({rf32, ri32[31:0], t[31:0], p[31:0]});
            t = p + ri64;
            exp64_q.push_back({rf64, ri64, t, p});
        end
        if (clr) begin
            cnt32_m = 0; cnt64_m = 0;
        end else if (acc) begin
            if (rf32 == 3'd7 && cnt32_m < 65535) cnt32_m++;
            if (rf64 == 3'd7 && cnt64_m < 3) cnt64_m++;
        end
    endtask

    task automatic send(input logic [31:0] ins, input logic [63:0] p, input logic clr);
        logic acc, ordy;
        acc = 1'b0;
        for (int k = 0; k < 100 && !acc; k++) begin
            if (stall_left > 0) begin
                ordy = 1'b0; stall_left--;
            end else begin
                ordy = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            step(1'b1, ins, p, ordy, clr, acc);
        end
        chk("send_accepted", 64'(acc), 64'(1));
    endtask

    task automatic drain();
        logic acc;
        for (int k = 0; k < 20 && exp32_q.size() != 0; k++)
            step(1'b0, $urandom, 64'h0, 1'b1, 1'b0, acc);
        chk("drain_empty", 64'(exp32_q.size()), 64'(0));
    endtask

    task automatic check_reset_vals();
        chk("rst_out_valid32", 64'(out_valid32), 64'(0));
        chk("rst_out_valid64", 64'(out_valid64), 64'(0));
        chk("rst_in_ready32", 64'(in_ready32), 64'(1));
        chk("rst_in_ready64", 64'(in_ready64), 64'(1));
        chk("rst_imm32", 64'(imm32), 64'(0));
        chk("rst_imm64", imm64, 64'(0));
        chk("rst_fmt32", 64'(fmt32), 64'(0));
        chk("rst_target32", 64'(target32), 64'(0));
        chk("rst_target64", target64, 64'(0));
        chk("rst_pc_out32", 64'(pc_out32), 64'(0));
        chk("rst_illegal32", 64'(illegal32), 64'(0));
        chk("rst_cnt32", 64'(cnt32), 64'(0));
        chk("rst_cnt64", 64'(cnt64), 64'(0));
    endtask

    task automatic apply_reset();
        rst = 1'b1; in_valid = 1'b0; cnt_clr = 1'b0;
        exp32_q.delete(); exp64_q.delete();
        cnt32_m = 0; cnt64_m = 0;
        #1;
        check_reset_vals();
        @(negedge clk);
        #3 rst = 1'b0;
    endtask

    task automatic directed(input logic [31:0] ins, input logic [63:0] p,
                            input logic [31:0] e_imm32, input logic [2:0] e_fmt,
                            input logic [31:0] e_tgt32, input logic [63:0] e_imm64);
        logic acc;
        drain();
        step(1'b1, ins, p, 1'b1, 1'b0, acc);
        #1;
        chk("dir_out_valid", 64'(out_valid32), 64'(1));
        chk("dir_imm32", 64'(imm32), 64'(e_imm32));
        chk("dir_fmt32", 64'(fmt32), 64'(e_fmt));
        chk("dir_target32", 64'(target32), 64'(e_tgt32));
        chk("dir_imm64", imm64, e_imm64);
    endtask

    // ---------------- scoreboard monitor
    initial begin
        logic [98:0]  e32;
        logic [194:0] e64;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                chk("in_ready32", 64'(in_ready32), 64'((exp32_q.size() == 0) || out_ready));
                chk("in_ready64", 64'(in_ready64), 64'((exp64_q.size() == 0) || out_ready));
                chk("out_valid32", 64'(out_valid32), 64'(exp32_q.size() != 0));
                chk("out_valid64", 64'(out_valid64), 64'(exp64_q.size() != 0));
                if (exp32_q.size() != 0) begin
                    e32 = exp32_q[0];
                    chk("fmt32", 64'(fmt32), 64'(e32[98:96]));
                    chk("imm32", 64'(imm32), 64'(e32[95:64]));
                    chk("target32", 64'(target32), 64'(e32[63:32]));
                    chk("pc_out32", 64'(pc_out32), 64'(e32[31:0]));
                    chk("illegal32", 64'(illegal32), 64'(e32[98:96] == 3'd7));
                    if (out_ready) void'(exp32_q.pop_front());
                end
                if (exp64_q.size() != 0) begin
                    e64 = exp64_q[0];
                    chk("fmt64", 64'(fmt64), 64'(e64[194:192]));
                    chk("imm64", imm64, e64[191:128]);
                    chk("target64", target64, e64[127:64]);
                    chk("pc_out64", pc_out64, e64[63:0]);
                    chk("illegal64", 64'(illegal64), 64'(e64[194:192] == 3'd7));
                    if (out_ready) void'(exp64_q.pop_front());
                end
                chk("illegal_cnt32", 64'(cnt32), 64'(cnt32_m));
                chk("illegal_cnt64", 64'(cnt64), 64'(cnt64_m));
            end
        end
    end

    // ---------------- main sequence
    initial begin
        logic acc;
        repeat (2) @(posedge clk);
        #3;
        apply_reset();

        directed(32'hFFF00093, 64'h100, 32'hFFFFFFFF, 3'd1, 32'h000000FF, 64'hFFFFFFFFFFFFFFFF);
        directed(32'hFE000EE3, 64'h200, 32'hFFFFFFFC, 3'd3, 32'h000001FC, 64'hFFFFFFFFFFFFFFFC);
        directed(32'h008000EF, 64'h100, 32'h00000008, 3'd5, 32'h00000108, 64'h8);
        directed(32'h123452B7, 64'h0, 32'h12345000, 3'd4, 32'h12345000, 64'h12345000);
        directed(32'h800002B7, 64'h0, 32'h80000000, 3'd4, 32'h80000000, 64'hFFFFFFFF80000000);
        drain();

        // Backpressure: four back-to-back instructions against a 3-cycle stall.
        stall_left = 3; rand_ready = 0;
        for (int i = 0; i < 4; i++) send(rand_instr(), {$urandom, $urandom}, 1'b0);
        drain();

        // Illegal encodings and counter saturation.
        apply_reset();
        send(32'h00000000, 64'h10, 1'b0);
        send(32'h02001013, 64'h14, 1'b0);
        send(32'h0000007F, 64'h18, 1'b0);
        drain();
        chk("cnt32_after_3", 64'(cnt32), 64'(3));
        chk("cnt64_after_3", 64'(cnt64), 64'(2));
        for (int i = 0; i < 5; i++) send(32'h00000000, 64'h20, 1'b0);
        drain();
        chk("cnt32_after_8", 64'(cnt32), 64'(8));
        chk("cnt64_saturated", 64'(cnt64), 64'(3));
        send(32'h00000000, 64'h24, 1'b1);
        drain();
        chk("cnt32_clr_priority", 64'(cnt32), 64'(0));
        chk("cnt64_clr_priority", 64'(cnt64), 64'(0));

        // Randomized traffic with gaps, random backpressure and occasional clears.
        rand_ready = 1;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0)
                step(1'b0, $urandom, 64'h0, ($urandom_range(0, 1) == 1), 1'b0, acc);
            send(rand_instr(), {$urandom, $urandom}, ($urandom_range(0, 19) == 0));
        end
        rand_ready = 0;
        drain();

        // Reset in the middle of a stall discards the held result immediately.
        step(1'b1, 32'h00100093, 64'h300, 1'b0, 1'b0, acc);
        step(1'b1, 32'h00200093, 64'h304, 1'b0, 1'b0, acc);
        #3;
        apply_reset();
        send(32'h00300093, 64'h308, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_decode_pipe.md
# imm_decode_pipe

Registered, handshaked immediate decoder for the RV32/RV64 datapath. It extracts the immediate directly from a raw 32-bit instruction word by opcode, with no control-unit op code needed. It sign-extends the immediate to XLEN, classifies the instruction format and precomputes pc+imm for branch, jump and AUIPC targets. It sits between fetch and execute as one valid/ready pipeline stage and keeps a saturating count of illegal encodings.

## Interface
- XLEN, 32: datapath width; legal values are 32 and 64 only.
- CNT_W, 16: width of the illegal-instruction counter.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  instruction and pc are presented.
- in_ready  out  1  stage can accept; equals !out_valid || out_ready.
- instr  in  32  raw instruction word.
- pc  in  XLEN  address of instr.
- out_valid  out  1  output register holds a decoded result.
- out_ready  in  1  consumer accepts the result.
- imm  out  XLEN  sign- or zero-extended immediate.
- fmt  out  3  format code: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHIFT, 7 ILLEGAL.
- target  out  XLEN  pc + imm, modulo 2^XLEN.
- pc_out  out  XLEN  registered copy of pc.
- illegal  out  1  equals (fmt == 7).
- illegal_cnt  out  CNT_W  saturating count of accepted illegal instructions.
- cnt_clr  in  1  synchronous clear of illegal_cnt.

## Operation
- Decode uses opcode instr[6:0]. Any instr[1:0] != 2'b11 is ILLEGAL.
- I format, opcodes 0000011, 1100111, 0010011 (except shifts): imm = sext(instr[31:20]).
- Opcode 0011011 (OP-IMM-32, non-shift): I format when XLEN=64, ILLEGAL when XLEN=32.
- SHIFT, OP-IMM with funct3 001 or 101:
  - XLEN=32: imm = zext(instr[24:20]). instr[25]=1 is ILLEGAL.
  - XLEN=64: imm = zext(instr[25:20]).
  - OP-IMM-32 shifts (XLEN=64 only): imm = zext(instr[24:20]); instr[25]=1 is ILLEGAL.
- S format, opcode 0100011: imm = sext({instr[31:25], instr[11:7]}).
- B format, opcode 1100011: imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
- U format, opcodes 0110111 and 0010111: imm = sext({instr[31:12], 12'b0}). Upper bits are sign-extended when XLEN=64.
- J format, opcode 1101111: imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
- R format, opcode 0110011 and (XLEN=64 only) 0111011: imm = 0.
- Every other opcode is ILLEGAL: imm = 0, fmt = 7.
- target is always pc + imm, whatever the format; the consumer decides whether to use it.
- illegal_cnt increments by 1 on each accepted illegal instruction and holds at 2^CNT_W-1.
- cnt_clr has priority over increment: if both occur in one cycle, the result is 0.

## Timing
- Latency is exactly 1 cycle. An instruction accepted in cycle N (in_valid && in_ready) has out_valid=1 from cycle N+1.
- Throughput is 1 instruction per cycle when out_ready stays high.
- Output registers load only on acceptance.
- When out_valid && !out_ready, all outputs hold stable and in_ready=0.
- When out_valid && out_ready && in_valid in the same cycle, the old result is retired and the new one is loaded with no bubble.
- When out_valid && out_ready && !in_valid, out_valid falls next cycle.
- A handshake asserted in the same cycle as an upstream withdrawal must not be lost or duplicated.
- Reset, asynchronous and applicable at any point including mid-transfer, forces:
  - out_valid=0, imm=0, fmt=0, target=0, pc_out=0, illegal=0, illegal_cnt=0.
  - Any in-flight result is discarded.
  - in_ready=1 as soon as reset is asserted.
- The stage has no combinational path from instr or pc to any output; the only input-to-output combinational path is out_ready to in_ready.

## Test plan
- Reset then ADDI (XLEN=32), instr=0xFFF00093, pc=0x100 -> next cycle out_valid=1, imm=0xFFFFFFFF, fmt=1, target=0x000000FF.
- BEQ backward, instr=0xFE000EE3, pc=0x200 -> imm=0xFFFFFFFC, fmt=3, target=0x1FC.
- JAL 0x008000EF, pc=0x100 -> imm=8, target=0x108.
- LUI 0x123452B7 -> imm=0x12345000, fmt=4. With XLEN=64, LUI 0x800002B7 -> imm=0xFFFFFFFF80000000.
- Backpressure: hold out_ready=0 for 3 cycles while in_valid=1 with 4 back-to-back instructions.
  - Outputs stay frozen and in_ready=0 during the stall.
  - After release, all 4 results appear in order with no drops or duplicates.
- Illegal and reset:
  - Send 0x00000000, 0x02001013 (XLEN=32, shamt bit 5 set) and 0x0000007F -> each gives fmt=7, illegal_cnt reaches 3.
  - With CNT_W=2 and 5 illegals -> illegal_cnt saturates at 3.
  - cnt_clr together with an illegal -> illegal_cnt=0.
  - rst asserted mid-stall -> out_valid=0 immediately.
